cortina_mando: RTL and testbench

Command-generation stage directly upstream of the curtain motor driver. Takes raw push-buttons, limit switches and the daylight sensor, conditions them, and runs a travel state machine that emits the 2-bit `accion` command consumed by the motor driver (SUBIR/BAJAR/stop). Adds end-of-travel stop, direction-reversal dead time and a travel watchdog, so the driver never sees an unsafe command sequence.

---
 rtl/cortina_mando_pkg.sv | 29 ++
 rtl/cortina_mando_antirrebote.sv | 50 +++++
 rtl/cortina_mando.sv | 150 +++++++++++++++
 tb/tb_cortina_mando.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cortina_mando_pkg.sv
// Shared motor-command encoding and travel-state enumeration for the curtain
// controller and the motor driver downstream of it.
package cortina_pkg;

  typedef enum logic [1:0] {
    PARAR = 2'b00,
    BAJAR = 2'b01,
    SUBIR = 2'b10
  } accion_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SUBIENDO = 3'd1,
    BAJANDO  = 3'd2,
    PAUSA    = 3'd3,
    FALLA    = 3'd4
  } estado_t;

  function automatic accion_t accion_de(input estado_t e);
    accion_t a;
    case (e)
      SUBIENDO: a = SUBIR;
      BAJANDO:  a = BAJAR;
      default:  a = PARAR;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cortina_mando_antirrebote.sv
// Two-flop synchronizer followed by a debouncer: the filtered level follows the
// synchronized input only after DEBOUNCE_CYCLES consecutive differing cycles.
module antirrebote #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic nivel
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          s1_q, s2_q;
  logic          nivel_q, nivel_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The count only ever reaches DEBOUNCE_CYCLES-1 before clearing, so it cannot wrap.
  always_comb begin
    nivel_d = nivel_q;
    cnt_d   = '0;
    if (s2_q != nivel_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        nivel_d = s2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      nivel_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      nivel_q <= nivel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign nivel = nivel_q;

endmodule

// File: rtl/cortina_mando.sv
// Curtain command generator: conditions buttons, limits and daylight, then runs
// the travel FSM with reversal dead time, watchdog and sensor-fault detection.
module cortina_mando
  import cortina_pkg::*;
#(
  parameter int CLK_HZ             = 50_000_000,
  parameter int DEBOUNCE_CYCLES    = 500_000,
  parameter int REVERSE_GAP_CYCLES = 25_000_000,
  parameter int MAX_TRAVEL_CYCLES  = 1_000_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_subir,
  input  logic       btn_bajar,
  input  logic       fin_arriba,
  input  logic       fin_abajo,
  input  logic       luz,
  input  logic       auto_en,
  output logic [1:0] accion,
  output logic       falla
);

  localparam int GW = (REVERSE_GAP_CYCLES > 1) ? $clog2(REVERSE_GAP_CYCLES) : 1;
  localparam int WW = (MAX_TRAVEL_CYCLES > 1) ? $clog2(MAX_TRAVEL_CYCLES) : 1;

  // CLK_HZ only documents the clock; every delay is expressed in cycles.
  if (CLK_HZ < 1) begin : g_clk_hz_unset
  end

  logic sub_f, baj_f, arr_f, aba_f, luz_f;

  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sub (.clk(clk), .rst_n(rst_n), .raw(btn_subir),  .nivel(sub_f));
  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_baj (.clk(clk), .rst_n(rst_n), .raw(btn_bajar),  .nivel(baj_f));
  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_arr (.clk(clk), .rst_n(rst_n), .raw(fin_arriba), .nivel(arr_f));
  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_aba (.clk(clk), .rst_n(rst_n), .raw(fin_abajo),  .nivel(aba_f));
  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_luz (.clk(clk), .rst_n(rst_n), .raw(luz),        .nivel(luz_f));

  estado_t       estado_q, estado_d;
  accion_t       pend_q, pend_d;
  accion_t       accion_q, accion_d;
  logic          falla_q, falla_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          sub_prev_q, baj_prev_q, luz_prev_q;
  logic          auto_s1_q, auto_s2_q;

  logic sub_ev, baj_ev, luz_rise, luz_fall;
  logic up_any, dn_any, up_req, dn_req;
  logic gap_exp, wd_exp, viajando;

  assign sub_ev   = sub_f & ~sub_prev_q;
  assign baj_ev   = baj_f & ~baj_prev_q;
  assign luz_rise = auto_s2_q & luz_f & ~luz_prev_q;
  assign luz_fall = auto_s2_q & ~luz_f & luz_prev_q;
  assign up_any   = sub_ev | luz_rise;
  assign dn_any   = baj_ev | luz_fall;
  assign up_req   = up_any & ~dn_any;
  assign dn_req   = dn_any & ~up_any;

  assign viajando = (estado_q == SUBIENDO) || (estado_q == BAJANDO);
  assign gap_exp  = (estado_q == PAUSA) && (gap_q == GW'(REVERSE_GAP_CYCLES - 1));
  assign wd_exp   = wd_q == WW'(MAX_TRAVEL_CYCLES - 1);

  // Both limits asserted at once is a sensor fault and overrides everything else.
  always_comb begin
    estado_d = estado_q;
    pend_d   = pend_q;
    if (arr_f && aba_f) begin
      estado_d = FALLA;
    end else begin
      case (estado_q)
        IDLE: begin
          if (up_req && !arr_f)      estado_d = SUBIENDO;
          else if (dn_req && !aba_f) estado_d = BAJANDO;
          else                       estado_d = IDLE;
        end
        SUBIENDO: begin
          if (arr_f)       estado_d = IDLE;
          else if (up_req) estado_d = IDLE;
          else if (dn_req) begin estado_d = PAUSA; pend_d = BAJAR; end
          else if (wd_exp) estado_d = FALLA;
          else             estado_d = SUBIENDO;
        end
        BAJANDO: begin
          if (aba_f)       estado_d = IDLE;
          else if (dn_req) estado_d = IDLE;
          else if (up_req) begin estado_d = PAUSA; pend_d = SUBIR; end
          else if (wd_exp) estado_d = FALLA;
          else             estado_d = BAJANDO;
        end
        PAUSA: begin
          if (!gap_exp)                        estado_d = PAUSA;
          else if (pend_q == SUBIR && !arr_f)  estado_d = SUBIENDO;
          else if (pend_q == BAJAR && !aba_f)  estado_d = BAJANDO;
          else                                 estado_d = IDLE;
        end
        FALLA: begin
          if (sub_ev || baj_ev) estado_d = IDLE;
          else                  estado_d = FALLA;
        end
        default: estado_d = IDLE;
      endcase
    end
  end

  always_comb begin
    gap_d = '0;
    wd_d  = '0;
    if (estado_q == PAUSA && gap_q != {GW{1'b1}}) gap_d = gap_q + GW'(1);
    else if (estado_q == PAUSA)                   gap_d = gap_q;
    else                                          gap_d = '0;
    if (viajando && wd_q != {WW{1'b1}}) wd_d = wd_q + WW'(1);
    else if (viajando)                  wd_d = wd_q;
    else                                wd_d = '0;
    accion_d = accion_de(estado_d);
    falla_d  = estado_d == FALLA;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= IDLE;
      pend_q     <= PARAR;
      accion_q   <= PARAR;
      falla_q    <= 1'b0;
      gap_q      <= '0;
      wd_q       <= '0;
      sub_prev_q <= 1'b0;
      baj_prev_q <= 1'b0;
      luz_prev_q <= 1'b0;
      auto_s1_q  <= 1'b0;
      auto_s2_q  <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      pend_q     <= pend_d;
      accion_q   <= accion_d;
      falla_q    <= falla_d;
      gap_q      <= gap_d;
      wd_q       <= wd_d;
      sub_prev_q <= sub_f;
      baj_prev_q <= baj_f;
      luz_prev_q <= luz_f;
      auto_s1_q  <= auto_en;
      auto_s2_q  <= auto_s1_q;
    end
  end

  assign accion = accion_q;
  assign falla  = falla_q;

endmodule

// File: tb/tb_cortina_mando.sv
// Self-checking bench for cortina_mando with short debounce, gap and watchdog limits.
module tb_cortina_mando;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_subir = 1'b0, btn_bajar = 1'b0;
  logic       fin_arriba = 1'b0, fin_abajo = 1'b0;
  logic       luz = 1'b0, auto_en = 1'b0;
  logic [1:0] accion;
  logic       falla;

  cortina_mando #(
    .CLK_HZ(50_000_000),
    .DEBOUNCE_CYCLES(4),
    .REVERSE_GAP_CYCLES(10),
    .MAX_TRAVEL_CYCLES(100)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_subir(btn_subir), .btn_bajar(btn_bajar),
    .fin_arriba(fin_arriba), .fin_abajo(fin_abajo),
    .luz(luz), .auto_en(auto_en),
    .accion(accion), .falla(falla)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] acc;
    logic       fal;
  } exp_t;

  typedef struct {
    string      name;
    logic       sub, baj, fa, fb, l, au;
    int         hold;
    logic [1:0] acc;
    logic       fal;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [1:0] P = 2'b00;
  localparam logic [1:0] U = 2'b10;
  localparam logic [1:0] D = 2'b01;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic compare();
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: no expected entry, accion=%b falla=%b", accion, falla);
    end else begin
      e = sb.pop_front();
      if (accion !== e.acc || falla !== e.fal) begin
        n_err++;
        $display("FAIL %s: got accion=%b falla=%b, want accion=%b falla=%b",
                 e.name, accion, falla, e.acc, e.fal);
      end
    end
  endtask

  task automatic chk(input string name, input logic [1:0] acc, input logic fal);
    sb.push_back('{name: name, acc: acc, fal: fal});
    compare();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // auto mode, fault entry/exit, manual light ignored, then a bouncing button
    tbl.push_back('{"auto_sync",       0,0,0,0,0,1, 3, P,1'b0});
    tbl.push_back('{"auto_pre",        0,0,0,0,1,1, 6, P,1'b0});
    tbl.push_back('{"auto_up",         0,0,0,0,1,1, 1, U,1'b0});
    tbl.push_back('{"both_limits",     0,0,1,1,1,1, 7, P,1'b1});
    tbl.push_back('{"limits_released", 0,0,0,0,1,1, 8, P,1'b1});
    tbl.push_back('{"falla_light_ign", 0,0,0,0,0,1, 8, P,1'b1});
    tbl.push_back('{"falla_btn_exit",  1,0,0,0,0,1, 7, P,1'b0});
    tbl.push_back('{"falla_idle",      0,0,0,0,0,1, 8, P,1'b0});
    tbl.push_back('{"manual_sync",     0,0,0,0,0,0, 3, P,1'b0});
    tbl.push_back('{"manual_luz_up",   0,0,0,0,1,0, 8, P,1'b0});
    tbl.push_back('{"manual_luz_dn",   0,0,0,0,0,0, 8, P,1'b0});
    for (int i = 0; i < 10; i++)
      tbl.push_back('{"bounce", 0,(i % 2 == 0),0,0,0,0, 2, P,1'b0});
    tbl.push_back('{"bounce_settle",   0,0,0,0,0,0, 8, P,1'b0});

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", P, 1'b0);
    rst_n = 1'b1;
    cyc(2);
    chk("post_reset", P, 1'b0);

    // press-to-move latency and limit stop
    btn_subir = 1'b1;
    cyc(6);  chk("lat_before", P, 1'b0);
    cyc(1);  chk("lat_up", U, 1'b0);
    cyc(1);  btn_subir = 1'b0; fin_arriba = 1'b1;
    cyc(6);  chk("lim_before", U, 1'b0);
    cyc(1);  chk("lim_stop", P, 1'b0);
    cyc(1);  fin_arriba = 1'b0;
    cyc(8);

    // asynchronous reset mid-travel
    btn_subir = 1'b1;
    cyc(7);  chk("rst_pre", U, 1'b0);
    cyc(1);  btn_subir = 1'b0;
    cyc(2);  rst_n = 1'b0;
    #1;      chk("rst_async", P, 1'b0);
    cyc(2);  rst_n = 1'b1;
    cyc(10); chk("rst_after", P, 1'b0);

    // reversal with exact dead time
    btn_subir = 1'b1;
    cyc(7);  chk("rev_up", U, 1'b0);
    cyc(1);  btn_subir = 1'b0; btn_bajar = 1'b1;
    cyc(6);  chk("rev_before", U, 1'b0);
    cyc(1);  chk("rev_gap_first", P, 1'b0);
    cyc(9);  chk("rev_gap_last", P, 1'b0);
    cyc(1);  chk("rev_down", D, 1'b0);
    btn_bajar = 1'b0;
    cyc(8);  btn_bajar = 1'b1;
    cyc(7);  chk("rev_stop", P, 1'b0);
    cyc(1);  btn_bajar = 1'b0;
    cyc(8);

    // reversal toward an active limit ends in IDLE
    btn_subir = 1'b1;
    cyc(7);  chk("revlim_up", U, 1'b0);
    cyc(1);  btn_subir = 1'b0; btn_bajar = 1'b1; fin_abajo = 1'b1;
    cyc(7);  chk("revlim_gap", P, 1'b0);
    cyc(10); chk("revlim_idle", P, 1'b0);
    cyc(5);  chk("revlim_stay", P, 1'b0);
    btn_bajar = 1'b0; fin_abajo = 1'b0;
    cyc(10);

    // travel watchdog
    btn_subir = 1'b1;
    cyc(7);  chk("wd_up", U, 1'b0);
    cyc(1);  btn_subir = 1'b0;
    cyc(98); chk("wd_last", U, 1'b0);
    cyc(1);  chk("wd_falla", P, 1'b1);
    btn_bajar = 1'b1;
    cyc(6);  chk("wd_hold", P, 1'b1);
    cyc(1);  chk("wd_clear", P, 1'b0);
    cyc(1);  btn_bajar = 1'b0;
    cyc(8);  chk("wd_idle", P, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      btn_subir  = tbl[i].sub;
      btn_bajar  = tbl[i].baj;
      fin_arriba = tbl[i].fa;
      fin_abajo  = tbl[i].fb;
      luz        = tbl[i].l;
      auto_en    = tbl[i].au;
      sb.push_back('{name: tbl[i].name, acc: tbl[i].acc, fal: tbl[i].fal});
      cyc(tbl[i].hold);
      compare();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
